// File: rtl/mem_write_monitor_pkg.sv
// Shared types for the memory write monitor: FSM encoding,
// fail-cause codes and the table index width helper.
package mem_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_e;

  localparam logic [1:0] FC_NONE      = 2'd0;
  localparam logic [1:0] FC_UNEXP_ADR = 2'd1;
  localparam logic [1:0] FC_DATA_MISM = 2'd2;
  localparam logic [1:0] FC_TIMEOUT   = 2'd3;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_write_monitor_if.sv
// Monitored processor store bus: MemWrite / DataAdr / WriteData.
// The processor side is the master, the monitor listens as slave.
interface mem_write_monitor_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              mem_write;
  logic [ADDR_W-1:0] data_adr;
  logic [DATA_W-1:0] write_data;

  modport master (
    output mem_write,
    output data_adr,
    output write_data
  );

  modport slave (
    input mem_write,
    input data_adr,
    input write_data
  );

endinterface

// File: rtl/mem_write_monitor_table.sv
// Expected (address, data) register file: sync write, sync
// active-low clear, combinational read at the check pointer.
module mem_mon_table #(
  parameter int NUM_EXP = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 2
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  input  logic [IDX_W-1:0]  i_ptr,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data
);

  logic [ADDR_W-1:0] r_addr [NUM_EXP];
  logic [DATA_W-1:0] r_data [NUM_EXP];

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_EXP; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else if (i_we && (int'(i_idx) < NUM_EXP)) begin
      r_addr[i_idx] <= i_addr;
      r_data[i_idx] <= i_data;
    end
  end

  assign o_addr = r_addr[i_ptr];
  assign o_data = r_data[i_ptr];

endmodule

// File: rtl/mem_write_monitor.sv
// In-order store checker against a loadable expected table.
// Optional RUN timeout is built when MEM_MON_TIMEOUT_EN is defined.
module mem_write_monitor
  import mem_mon_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_EXP     = 4,
  parameter int TIMEOUT_CYC = 1000,
  localparam int IDX_W      = idx_w(NUM_EXP)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [IDX_W:0]    cfg_num,
  input  logic [ADDR_W-1:0] ign_addr,
  input  logic              start,
  mem_write_monitor_if.slave bus,
  output logic              busy,
  output logic              pass,
  output logic              fail,
  output logic [1:0]        fail_code,
  output logic [ADDR_W-1:0] fail_adr,
  output logic [DATA_W-1:0] fail_data,
  output logic [IDX_W:0]    match_cnt
);

  localparam logic [IDX_W:0]   NUM_MAX = (IDX_W+1)'(NUM_EXP);
  localparam logic [IDX_W:0]   CNT_ONE = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] PTR_ONE = IDX_W'(1);

  state_e            r_state;
  logic              r_busy;
  logic              r_pass;
  logic              r_fail;
  logic [1:0]        r_code;
  logic [ADDR_W-1:0] r_adr;
  logic [DATA_W-1:0] r_data;
  logic [IDX_W-1:0]  r_ptr;
  logic [IDX_W:0]    r_cnt;
  logic [IDX_W:0]    r_num;

  logic [ADDR_W-1:0] w_exp_addr;
  logic [DATA_W-1:0] w_exp_data;
  logic              w_tbl_we;
  logic              w_wr;
  logic              w_adr_hit;
  logic              w_dat_hit;
  logic              w_ign_hit;
  logic              w_match;
  logic              w_last;
  logic              w_to_hit;
  logic [IDX_W:0]    w_num;

  // A same-edge start keeps the old entry, so that write is dropped
  assign w_tbl_we  = cfg_we && (r_state != RUN) && !start;
  assign w_wr      = (r_state == RUN) && bus.mem_write;
  assign w_adr_hit = (bus.data_adr == w_exp_addr);
  assign w_dat_hit = (bus.write_data == w_exp_data);
  assign w_ign_hit = (bus.data_adr == ign_addr);
  assign w_match   = w_wr && w_adr_hit && w_dat_hit && (r_num != '0);
  assign w_last    = ((r_cnt + CNT_ONE) == r_num);
  assign w_num     = (cfg_num > NUM_MAX) ? NUM_MAX : cfg_num;

  mem_mon_table #(
    .NUM_EXP (NUM_EXP),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .IDX_W   (IDX_W)
  ) u_table (
    .clk     (clk),
    .i_rst_n (reset),
    .i_we    (w_tbl_we),
    .i_idx   (cfg_idx),
    .i_addr  (cfg_addr),
    .i_data  (cfg_data),
    .i_ptr   (r_ptr),
    .o_addr  (w_exp_addr),
    .o_data  (w_exp_data)
  );

`ifdef MEM_MON_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  logic [TO_W-1:0] r_to_cnt;

  // Held at zero outside RUN, so a start always begins a fresh budget
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_to_cnt <= '0;
    end else if (r_state != RUN) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TO_ONE;
    end
  end

  assign w_to_hit = (r_to_cnt == TO_LAST);
`else
  logic w_unused_to;
  assign w_unused_to = (TIMEOUT_CYC != 0);
  assign w_to_hit    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_pass  <= 1'b0;
      r_fail  <= 1'b0;
      r_code  <= FC_NONE;
      r_adr   <= '0;
      r_data  <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_num   <= '0;
    end else begin
      unique case (r_state)
        IDLE, PASS, FAIL: begin
          if (start) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_pass  <= 1'b0;
            r_fail  <= 1'b0;
            r_code  <= FC_NONE;
            r_adr   <= '0;
            r_data  <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_num   <= w_num;
          end
        end
        RUN: begin
          if (w_match) begin
            r_ptr <= r_ptr + PTR_ONE;
            r_cnt <= r_cnt + CNT_ONE;
          end
          if (r_num == '0 || (w_match && w_last)) begin
            r_state <= PASS;
            r_busy  <= 1'b0;
            r_pass  <= 1'b1;
          end else if (w_wr && !w_match && !w_ign_hit) begin
            r_state <= FAIL;
            r_busy  <= 1'b0;
            r_fail  <= 1'b1;
            r_code  <= w_adr_hit ? FC_DATA_MISM : FC_UNEXP_ADR;
            r_adr   <= bus.data_adr;
            r_data  <= bus.write_data;
          end else if (w_to_hit) begin
            r_state <= FAIL;
            r_busy  <= 1'b0;
            r_fail  <= 1'b1;
            r_code  <= FC_TIMEOUT;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign pass      = r_pass;
  assign fail      = r_fail;
  assign fail_code = r_code;
  assign fail_adr  = r_adr;
  assign fail_data = r_data;
  assign match_cnt = r_cnt;

endmodule

// File: tb/tb_mem_write_monitor.sv
// Scoreboard bench for mem_write_monitor; follows MEM_MON_TIMEOUT_EN
// to pick the timeout or the wait-forever scenario.
module tb_mem_write_monitor;

  localparam int TO_CYC = 20;

  typedef struct {
    logic        pass;
    logic        fail;
    logic [1:0]  code;
    logic [31:0] adr;
    logic [31:0] data;
    logic [2:0]  cnt;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [31:0] cfg_addr;
  logic [31:0] cfg_data;
  logic [2:0]  cfg_num;
  logic [31:0] ign_addr;
  logic        start;
  logic        busy;
  logic        pass;
  logic        fail;
  logic [1:0]  fail_code;
  logic [31:0] fail_adr;
  logic [31:0] fail_data;
  logic [2:0]  match_cnt;

  int   checks;
  int   errors;
  exp_t sb[$];
  exp_t e;
  bit   ok;

  mem_write_monitor_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_write_monitor #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .NUM_EXP     (4),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_num   (cfg_num),
    .ign_addr  (ign_addr),
    .start     (start),
    .bus       (bus),
    .busy      (busy),
    .pass      (pass),
    .fail      (fail),
    .fail_code (fail_code),
    .fail_adr  (fail_adr),
    .fail_data (fail_data),
    .match_cnt (match_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cfg_entry(input logic [1:0] i, input logic [31:0] a,
                           input logic [31:0] d);
    cfg_we = 1'b1; cfg_idx = i; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic do_start(input logic [2:0] n);
    start = 1'b1; cfg_num = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    bus.mem_write = 1'b1; bus.data_adr = a; bus.write_data = d;
    @(negedge clk);
    bus.mem_write = 1'b0;
  endtask

  task automatic wait_done(output bit done);
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst.busy got %0b want 0", busy); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL rst.pass got %0b want 0", pass); end
    checks++; if (fail !== 1'b0) begin errors++; $display("FAIL rst.fail got %0b want 0", fail); end
    checks++; if (fail_code !== 2'd0) begin errors++; $display("FAIL rst.code got %0d want 0", fail_code); end
    checks++; if (match_cnt !== 3'd0) begin errors++; $display("FAIL rst.cnt got %0d want 0", match_cnt); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_pass_ign;
    cfg_entry(2'd0, 32'd100, 32'd7);
    do_start(3'd1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign.busy_start got %0b want 1", busy); end
    bus_wr(32'd96, 32'd5);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign.busy_after_ign got %0b want 1", busy); end
    sb.push_back('{pass: 1'b1, fail: 1'b0, code: 2'd0, adr: 32'd0, data: 32'd0, cnt: 3'd1});
    bus_wr(32'd100, 32'd7);
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL ign.pass_edge got %0b want 1", pass); end
    wait_done(ok);
    e = sb.pop_front();
    checks++; if (!ok) begin errors++; $display("FAIL ign.done got busy want idle"); end
    checks++; if (pass !== e.pass) begin errors++; $display("FAIL ign.pass got %0b want %0b", pass, e.pass); end
    checks++; if (fail_code !== e.code) begin errors++; $display("FAIL ign.code got %0d want %0d", fail_code, e.code); end
    checks++; if (match_cnt !== e.cnt) begin errors++; $display("FAIL ign.cnt got %0d want %0d", match_cnt, e.cnt); end
  endtask

  task automatic test_data_mism;
    do_start(3'd1);
    sb.push_back('{pass: 1'b0, fail: 1'b1, code: 2'd2, adr: 32'd100, data: 32'd8, cnt: 3'd0});
    bus_wr(32'd100, 32'd8);
    wait_done(ok);
    e = sb.pop_front();
    checks++; if (!ok) begin errors++; $display("FAIL mism.done got busy want idle"); end
    checks++; if (fail !== e.fail || pass !== e.pass) begin errors++; $display("FAIL mism.flags got p%0b f%0b want p%0b f%0b", pass, fail, e.pass, e.fail); end
    checks++; if (fail_code !== e.code) begin errors++; $display("FAIL mism.code got %0d want %0d", fail_code, e.code); end
    checks++; if (fail_adr !== e.adr) begin errors++; $display("FAIL mism.adr got %0d want %0d", fail_adr, e.adr); end
    checks++; if (fail_data !== e.data) begin errors++; $display("FAIL mism.data got %0d want %0d", fail_data, e.data); end
  endtask

  task automatic test_unexp_restart;
    cfg_entry(2'd1, 32'd104, 32'd9);
    do_start(3'd2);
    sb.push_back('{pass: 1'b0, fail: 1'b1, code: 2'd1, adr: 32'd104, data: 32'd9, cnt: 3'd0});
    bus_wr(32'd104, 32'd9);
    wait_done(ok);
    e = sb.pop_front();
    checks++; if (fail !== e.fail) begin errors++; $display("FAIL unexp.fail got %0b want %0b", fail, e.fail); end
    checks++; if (fail_code !== e.code) begin errors++; $display("FAIL unexp.code got %0d want %0d", fail_code, e.code); end
    checks++; if (match_cnt !== e.cnt) begin errors++; $display("FAIL unexp.cnt got %0d want %0d", match_cnt, e.cnt); end
    checks++; if (fail_adr !== e.adr) begin errors++; $display("FAIL unexp.adr got %0d want %0d", fail_adr, e.adr); end
    do_start(3'd2);
    checks++; if (fail !== 1'b0 || fail_code !== 2'd0) begin errors++; $display("FAIL restart.clear got f%0b c%0d want f0 c0", fail, fail_code); end
    sb.push_back('{pass: 1'b1, fail: 1'b0, code: 2'd0, adr: 32'd0, data: 32'd0, cnt: 3'd2});
    bus_wr(32'd100, 32'd7);
    checks++; if (match_cnt !== 3'd1 || busy !== 1'b1) begin errors++; $display("FAIL restart.mid got cnt%0d busy%0b want cnt1 busy1", match_cnt, busy); end
    bus_wr(32'd96, 32'd1);
    bus_wr(32'd104, 32'd9);
    wait_done(ok);
    e = sb.pop_front();
    checks++; if (pass !== e.pass || fail !== e.fail) begin errors++; $display("FAIL restart.flags got p%0b f%0b want p%0b f%0b", pass, fail, e.pass, e.fail); end
    checks++; if (match_cnt !== e.cnt) begin errors++; $display("FAIL restart.cnt got %0d want %0d", match_cnt, e.cnt); end
  endtask

  task automatic test_timeout;
    int n;
    do_start(3'd1);
`ifdef MEM_MON_TIMEOUT_EN
    sb.push_back('{pass: 1'b0, fail: 1'b1, code: 2'd3, adr: 32'd0, data: 32'd0, cnt: 3'd0});
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    checks++; if (n != TO_CYC) begin errors++; $display("FAIL tmo.edges got %0d want %0d", n, TO_CYC); end
    checks++; if (fail !== e.fail) begin errors++; $display("FAIL tmo.fail got %0b want %0b", fail, e.fail); end
    checks++; if (fail_code !== e.code) begin errors++; $display("FAIL tmo.code got %0d want %0d", fail_code, e.code); end
    checks++; if (fail_adr !== e.adr) begin errors++; $display("FAIL tmo.adr got %0d want %0d", fail_adr, e.adr); end
`else
    n = 0;
    repeat (100) @(negedge clk);
    checks++; if (busy !== 1'b1 || fail !== 1'b0) begin errors++; $display("FAIL notmo.busy got busy%0b fail%0b want busy1 fail0", busy, fail); end
    sb.push_back('{pass: 1'b1, fail: 1'b0, code: 2'd0, adr: 32'd0, data: 32'd0, cnt: 3'd1});
    bus_wr(32'd100, 32'd7);
    wait_done(ok);
    e = sb.pop_front();
    checks++; if (pass !== e.pass || fail_code !== e.code) begin errors++; $display("FAIL notmo.end got p%0b c%0d want p%0b c%0d", pass, fail_code, e.pass, e.code); end
`endif
  endtask

  task automatic test_reset_midrun;
    do_start(3'd2);
    bus_wr(32'd100, 32'd7);
    checks++; if (match_cnt !== 3'd1) begin errors++; $display("FAIL rmid.cnt_pre got %0d want 1", match_cnt); end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checks++; if (busy !== 1'b0 || pass !== 1'b0 || fail !== 1'b0) begin errors++; $display("FAIL rmid.flags got b%0b p%0b f%0b want 0 0 0", busy, pass, fail); end
    checks++; if (match_cnt !== 3'd0 || fail_code !== 2'd0) begin errors++; $display("FAIL rmid.cnt got cnt%0d c%0d want 0 0", match_cnt, fail_code); end
    checks++; if (fail_adr !== 32'd0 || fail_data !== 32'd0) begin errors++; $display("FAIL rmid.cap got %0d/%0d want 0/0", fail_adr, fail_data); end
    do_start(3'd1);
    sb.push_back('{pass: 1'b1, fail: 1'b0, code: 2'd0, adr: 32'd0, data: 32'd0, cnt: 3'd1});
    bus_wr(32'd0, 32'd0);
    wait_done(ok);
    e = sb.pop_front();
    checks++; if (pass !== e.pass || match_cnt !== e.cnt) begin errors++; $display("FAIL rmid.zero_tbl got p%0b cnt%0d want p%0b cnt%0d", pass, match_cnt, e.pass, e.cnt); end
  endtask

  task automatic test_zero_num;
    do_start(3'd0);
    checks++; if (busy !== 1'b1 || pass !== 1'b0) begin errors++; $display("FAIL zero.entry got b%0b p%0b want b1 p0", busy, pass); end
    sb.push_back('{pass: 1'b1, fail: 1'b0, code: 2'd0, adr: 32'd0, data: 32'd0, cnt: 3'd0});
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (pass !== e.pass || busy !== 1'b0) begin errors++; $display("FAIL zero.pass got p%0b b%0b want p%0b b0", pass, busy, e.pass); end
    checks++; if (match_cnt !== e.cnt) begin errors++; $display("FAIL zero.cnt got %0d want %0d", match_cnt, e.cnt); end
  endtask

  task automatic test_cfg_during_run;
    cfg_entry(2'd0, 32'd200, 32'd3);
    do_start(3'd1);
    cfg_entry(2'd0, 32'd300, 32'd4);
    sb.push_back('{pass: 1'b1, fail: 1'b0, code: 2'd0, adr: 32'd0, data: 32'd0, cnt: 3'd1});
    bus_wr(32'd200, 32'd3);
    wait_done(ok);
    e = sb.pop_front();
    checks++; if (pass !== e.pass || fail_code !== e.code) begin errors++; $display("FAIL cfgrun.result got p%0b c%0d want p%0b c%0d", pass, fail_code, e.pass, e.code); end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++)
      cfg_entry(2'(i), 32'h200 + 32'(4 * i), 32'h10 + 32'(i));
    do_start(3'd7);
    sb.push_back('{pass: 1'b1, fail: 1'b0, code: 2'd0, adr: 32'd0, data: 32'd0, cnt: 3'd4});
    for (int i = 0; i < 4; i++)
      bus_wr(32'h200 + 32'(4 * i), 32'h10 + 32'(i));
    wait_done(ok);
    e = sb.pop_front();
    checks++; if (!ok) begin errors++; $display("FAIL b2b.done got busy want idle"); end
    checks++; if (pass !== e.pass || fail !== e.fail) begin errors++; $display("FAIL b2b.flags got p%0b f%0b want p%0b f%0b", pass, fail, e.pass, e.fail); end
    checks++; if (match_cnt !== e.cnt) begin errors++; $display("FAIL b2b.cnt got %0d want %0d", match_cnt, e.cnt); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    cfg_we = 1'b0;
    cfg_idx = '0;
    cfg_addr = '0;
    cfg_data = '0;
    cfg_num = '0;
    ign_addr = 32'd96;
    start = 1'b0;
    bus.mem_write = 1'b0;
    bus.data_adr = '0;
    bus.write_data = '0;
    @(negedge clk);
    test_reset;
    test_pass_ign;
    test_data_mism;
    test_unexp_restart;
    test_timeout;
    test_reset_midrun;
    test_zero_num;
    test_cfg_during_run;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_write_monitor.md
# mem_write_monitor

Synthesizable, parametrised successor to the processor bench's hard-coded write checker. It watches the `MemWrite`/`DataAdr`/`WriteData` bus of `top`, and checks the writes in order against a loadable table of up to `NUM_EXP` expected (address, data) pairs. Writes to one tolerated scratch address are ignored. It reports sticky pass/fail with a cause code, and can therefore sit in the bench or on an FPGA self-test harness beside `top`.

## Interface
- `ADDR_W`, 32, width of `data_adr`
- `DATA_W`, 32, width of `write_data`
- `NUM_EXP`, 4, expected-table depth (≥1); `IDX_W = $clog2(NUM_EXP)` (min 1)
- `TIMEOUT_CYC`, 1000, RUN-cycle budget before timeout fail (only with `MEM_MON_TIMEOUT_EN`)

Ports:
- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: synchronous, active-low; 0 at a rising edge resets everything
- `cfg_we` in 1: write table entry `cfg_idx` (IDLE/PASS/FAIL only)
- `cfg_idx` in IDX_W; `cfg_addr` in ADDR_W; `cfg_data` in DATA_W
- `cfg_num` in IDX_W+1: number of valid entries, sampled on `start`
- `ign_addr` in ADDR_W: tolerated address (96 in the current program)
- `start` in 1: begin/restart a check run
- `mem_write` in 1; `data_adr` in ADDR_W; `write_data` in DATA_W: monitored bus
- `busy` out 1: in RUN
- `pass`, `fail` out 1: sticky results, mutually exclusive
- `fail_code` out 2: 0 none, 1 unexpected address, 2 data mismatch, 3 timeout
- `fail_adr` out ADDR_W, `fail_data` out DATA_W: captured offending write
- `match_cnt` out IDX_W+1: expected writes matched so far

## Operation
- States: IDLE, RUN, PASS, FAIL. Reset → IDLE. Outputs reset to 0. Table entries reset to 0. `ptr` reset to 0.
- IDLE/PASS/FAIL: `cfg_we` writes the entry. `start` → RUN; it clears `ptr`, `match_cnt`, `fail_*` and the timeout counter, and latches `cfg_num`.
- RUN: `cfg_we` and `start` are ignored. When `mem_write`=1, each cycle is classified in priority order:
  1. `data_adr`==exp_addr[ptr] and `write_data`==exp_data[ptr]: `ptr`++ and `match_cnt`++. If this was entry `cfg_num`-1 → PASS.
  2. `data_adr`==`ign_addr`: no effect, including a data mismatch at an address that is also the expected address.
  3. `data_adr`==exp_addr[ptr] → FAIL, code 2.
  4. Otherwise → FAIL, code 1.
- On FAIL, `fail_adr` and `fail_data` capture the bus values.
- `mem_write`=0: no check. X/Z on the bus while `mem_write`=1 compares as mismatch.
- `cfg_num`=0 at `start` → PASS one cycle after RUN entry, with no bus check.
- `cfg_num`>NUM_EXP is clamped to NUM_EXP.
- Writes after PASS/FAIL are ignored. Results hold until `start` or reset.
- Reset mid-run: aborts the run, clears all state, returns to IDLE.

## Timing
- `start` at edge N → `busy`=1 after edge N. The bus is checked from cycle N+1.
- A qualifying write sampled at edge M → `pass`/`fail`/`fail_code`/`match_cnt` update after edge M, and `busy` drops at the same time. All outputs are registered.
- `cfg_we` at edge K → the entry is usable by a `start` at edge K+1 or later. A same-edge `cfg_we`+`start` uses the old entry.
- Timeout: RUN lasting `TIMEOUT_CYC` cycles without PASS → FAIL code 3 at the `TIMEOUT_CYC`-th RUN edge. A match on that same edge wins over the timeout.

## Configuration
- `MEM_MON_TIMEOUT_EN` defined: a cycle counter of width $clog2(TIMEOUT_CYC+1) is built and code 3 is reachable.
- Undefined: no counter is built, RUN waits indefinitely, and code 3 is never produced.

## Structure
- Shared package `mem_mon_pkg`: state encoding (IDLE=0, RUN=1, PASS=2, FAIL=3) and fail-code constants (FC_NONE, FC_UNEXP_ADR, FC_DATA_MISM, FC_TIMEOUT).
- One sub-module `mem_mon_table`: NUM_EXP×(ADDR_W+DATA_W) register file with synchronous write, active-low sync clear, and combinational read at `ptr`.
- The FSM, classifier and counters stay in `mem_write_monitor`.

## Test plan
- Table {(100,7)}, ign 96, `cfg_num`=1; bus writes (96,5) then (100,7) → `pass`=1 one edge after the second write, `match_cnt`=1, `fail_code`=0.
- Same table; bus write (100,8) → `fail`=1, code 2, `fail_adr`=100, `fail_data`=8.
- Table {(100,7),(104,9)}, `cfg_num`=2; writes (104,9) → FAIL code 1 with `match_cnt`=0. Then restart and write (100,7),(96,1),(104,9) → PASS with `match_cnt`=2.
- `MEM_MON_TIMEOUT_EN`, `TIMEOUT_CYC`=20, no writes → FAIL code 3 exactly 20 edges after RUN entry. Repeat with the macro undefined → still `busy` after 100 cycles.
- Reset low for one edge mid-run after 1 match → all outputs 0 and state IDLE. Table reads back 0, so `start` with `cfg_num`=1 plus bus write (0,0) → PASS.
- `cfg_num`=0 with `start` → PASS after 1 edge. `cfg_we` during RUN leaves the table unchanged.
